// File: rtl/mccpu_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, decode
// classes, datapath strobe codes and trap causes.
package mccpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LUI, CLS_LOAD, CLS_STORE,
        CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILL
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_BNE  = 5'b00101;
    localparam logic [4:0] ALU_BLT  = 5'b00110;
    localparam logic [4:0] ALU_BGE  = 5'b00111;
    localparam logic [4:0] ALU_BLTU = 5'b01000;
    localparam logic [4:0] ALU_BGEU = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef struct packed {
        cls_t       cls;
        logic [4:0] alu_op;
        logic [5:0] ext_op;
        logic       alu_src;
    } dec_t;

    // R-type and I-ALU share funct3 meaning; only R-type may select sub.
    function automatic logic [4:0] alu_arith(input logic [2:0] f3, input logic alt,
                                             input logic is_r);
        logic [4:0] r;
        case (f3)
            3'b000:  r = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mccpu_decode.sv
// Combinational instruction classifier: legality, ALU op, immediate type and
// ALU B-operand select for the IR-latched opcode fields.
module mccpu_decode
    import mccpu_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [6:0] f7,
    input  logic [2:0] f3,
    output dec_t       dec
);

    always_comb begin
        dec     = '0;
        dec.cls = CLS_ILL;
        case (op)
            OP_R: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec.cls    = CLS_R;
                    dec.alu_op = alu_arith(f3, f7[5], 1'b1);
                end
            end
            OP_I: begin
                // Shift-immediates carry funct7 in imm[11:5]; only srai may set bit 5.
                if ((f3 == 3'b001 && f7 == 7'b0000000) ||
                    (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
                    (f3 != 3'b001 && f3 != 3'b101)) begin
                    dec.cls     = CLS_I;
                    dec.alu_op  = alu_arith(f3, f7[5], 1'b0);
                    dec.ext_op  = (f3 == 3'b001 || f3 == 3'b101) ? EXT_SHAMT : EXT_I;
                    dec.alu_src = 1'b1;
                end
            end
            OP_LUI: begin
                dec.cls     = CLS_LUI;
                dec.alu_op  = ALU_LUI;
                dec.ext_op  = EXT_U;
                dec.alu_src = 1'b1;
            end
            OP_LOAD: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    dec.cls     = CLS_LOAD;
                    dec.alu_op  = ALU_ADD;
                    dec.ext_op  = EXT_I;
                    dec.alu_src = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) begin
                    dec.cls     = CLS_STORE;
                    dec.alu_op  = ALU_ADD;
                    dec.ext_op  = EXT_S;
                    dec.alu_src = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec.ext_op = EXT_B;
                dec.cls    = CLS_BRANCH;
                case (f3)
                    3'b000:  dec.alu_op = ALU_SUB;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: dec.cls    = CLS_ILL;
                endcase
            end
            OP_JAL: begin
                dec.cls    = CLS_JAL;
                dec.ext_op = EXT_J;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    dec.cls    = CLS_JALR;
                    dec.ext_op = EXT_I;
                end
            end
            default: dec.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mccpu_ctrl.sv
// Multicycle RV32I control FSM with memory handshake, timeout and trapping.
// Define MCCPU_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module mccpu_ctrl
    import mccpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef MCCPU_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] Op,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ALUSrc,
    output logic [5:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic [1:0] WDSel,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
`ifdef MCCPU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t          state, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            to_hit;
    dec_t            dec;

    mccpu_decode u_decode (
        .op  (Op),
        .f7  (Funct7),
        .f3  (Funct3),
        .dec (dec)
    );

    // A ready on the last allowed cycle still completes the access.
    assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST) && !mem_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_RST;
            cause_q <= CAUSE_NONE;
            to_cnt  <= '0;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            to_cnt  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        cause_d  = cause_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrc   = 1'b0;
        EXTOp    = '0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PLUS4;
        WDSel    = WD_ALU;
        case (state)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (dec.cls)
                    CLS_R, CLS_I, CLS_LUI, CLS_LOAD, CLS_STORE: state_d = S_EXEC;
                    CLS_BRANCH:       state_d = S_BRANCH;
                    CLS_JAL, CLS_JALR: state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                ALUOp   = dec.alu_op;
                EXTOp   = dec.ext_op;
                ALUSrc  = dec.alu_src;
                state_d = (dec.cls == CLS_LOAD || dec.cls == CLS_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec.cls == CLS_STORE);
                if (mem_ready) begin
                    state_d = (dec.cls == CLS_STORE) ? S_FETCH : S_WB;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                WDSel    = (dec.cls == CLS_LOAD) ? WD_MEM : WD_ALU;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                // PC already holds PC+4; the datapath forms the target from the old PC.
                ALUOp   = dec.alu_op;
                EXTOp   = EXT_B;
                NPCOp   = NPC_BRANCH;
                PCWrite = Zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                RegWrite = 1'b1;
                WDSel    = WD_PC4;
                PCWrite  = 1'b1;
                NPCOp    = (dec.cls == CLS_JAL) ? NPC_JAL : NPC_JALR;
                EXTOp    = (dec.cls == CLS_JAL) ? EXT_J : EXT_I;
                state_d  = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        to_cnt_d = to_cnt;
        if (state_d != state) begin
            to_cnt_d = '0;
        end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
            to_cnt_d = to_cnt + TO_W'(1);
        end
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state;

`ifdef MCCPU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_RST && state != S_TRAP) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (state_d == S_FETCH &&
                (state == S_WB || state == S_MEM || state == S_BRANCH || state == S_JUMP)) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed self-checking bench for mccpu_ctrl (timeout shortened to 4 cycles).
module tb_mccpu_ctrl;

    localparam int TO = 4;
    localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3;
    localparam logic [3:0] ST_MEM = 4'd4, ST_WB = 4'd5, ST_BRANCH = 4'd6, ST_JUMP = 4'd7;
    localparam logic [3:0] ST_TRAP = 4'd8;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] Op, Funct7;
    logic [2:0] Funct3;
    logic       Zero, mem_ready;
    logic       mem_req, mem_we, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrc;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_o;
`ifdef MCCPU_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif
    logic [22:0] strobes;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mccpu_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrc(ALUSrc), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel),
        .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
`ifdef MCCPU_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    assign strobes = {mem_req, mem_we, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrc,
                      EXTOp, ALUOp, NPCOp, WDSel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle_state(input string tag, input logic [3:0] exp);
        #1;
        check(tag, 32'(state_o), 32'(exp));
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
        Op = op;
        Funct7 = f7;
        Funct3 = f3;
    endtask

    // Assumes FETCH; completes it with an immediate ready and lands in DECODE.
    task automatic fetch(input string tag);
        mem_ready = 1'b1;
        #1;
        check({tag, "_irwrite"}, 32'(IRWrite), 32'd1);
        check({tag, "_pcwrite"}, 32'(PCWrite), 32'd1);
        check({tag, "_npc4"}, 32'(NPCOp), 32'd0);
        tick();
        mem_ready = 1'b0;
        settle_state({tag, "_decode"}, ST_DECODE);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(state_o), 32'(ST_RST));
        check({tag, "_rst_trap"}, 32'(trap), 32'd0);
        check({tag, "_rst_cause"}, 32'(trap_cause), 32'd0);
        check({tag, "_rst_strobes"}, 32'(strobes), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        settle_state({tag, "_fetch"}, ST_FETCH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        set_ir(7'b0110011, 7'd0, 3'd0);
        Zero = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("reset_state", 32'(state_o), 32'(ST_RST));
        check("reset_strobes", 32'(strobes), 32'd0);
        check("reset_trap", 32'(trap), 32'd0);
        check("reset_cause", 32'(trap_cause), 32'd0);
        tick();
        settle_state("reset_hold", ST_RST);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        settle_state("rst_to_fetch", ST_FETCH);

        // add with ready delayed two cycles
        check("add_f1_req", 32'(mem_req), 32'd1);
        check("add_f1_irw", 32'(IRWrite), 32'd0);
        tick();
        settle_state("add_f2", ST_FETCH);
        tick();
        settle_state("add_f3", ST_FETCH);
        fetch("add");
        tick();
        settle_state("add_exec", ST_EXEC);
        check("add_aluop", 32'(ALUOp), 32'h03);
        check("add_alusrc", 32'(ALUSrc), 32'd0);
        tick();
        settle_state("add_wb", ST_WB);
        check("add_regwrite", 32'(RegWrite), 32'd1);
        check("add_wdsel", 32'(WDSel), 32'd0);
        tick();
        settle_state("add_back", ST_FETCH);
        check("add_rw_once", 32'(RegWrite), 32'd0);
`ifdef MCCPU_PERF_CNT_EN
        check("perf_cyc", cyc_cnt, 32'd6);
        check("perf_ret", ret_cnt, 32'd1);
`endif

        // lw
        set_ir(7'b0000011, 7'd0, 3'b010);
        fetch("lw");
        tick();
        settle_state("lw_exec", ST_EXEC);
        check("lw_alusrc", 32'(ALUSrc), 32'd1);
        check("lw_ext", 32'(EXTOp), 32'h10);
        check("lw_aluop", 32'(ALUOp), 32'h03);
        tick();
        settle_state("lw_mem", ST_MEM);
        check("lw_req", 32'(mem_req), 32'd1);
        check("lw_we", 32'(mem_we), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        settle_state("lw_wb", ST_WB);
        check("lw_regwrite", 32'(RegWrite), 32'd1);
        check("lw_wdsel", 32'(WDSel), 32'd1);
        tick();
        settle_state("lw_back", ST_FETCH);

        // sw
        set_ir(7'b0100011, 7'd0, 3'b010);
        fetch("sw");
        check("sw_dec_rw", 32'(RegWrite), 32'd0);
        tick();
        settle_state("sw_exec", ST_EXEC);
        check("sw_ext", 32'(EXTOp), 32'h08);
        check("sw_rw_exec", 32'(RegWrite), 32'd0);
        tick();
        settle_state("sw_mem", ST_MEM);
        mem_ready = 1'b1;
        #1;
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_rw_mem", 32'(RegWrite), 32'd0);
        tick();
        mem_ready = 1'b0;
        settle_state("sw_back", ST_FETCH);
        check("sw_rw_fetch", 32'(RegWrite), 32'd0);

        // beq taken, then not taken
        for (int z = 1; z >= 0; z--) begin
            set_ir(7'b1100011, 7'd0, 3'b000);
            Zero = 1'(z);
            fetch("beq");
            tick();
            settle_state("beq_branch", ST_BRANCH);
            check("beq_aluop", 32'(ALUOp), 32'h04);
            check("beq_ext", 32'(EXTOp), 32'h04);
            check("beq_pcwrite", 32'(PCWrite), 32'(z));
            if (z == 1) check("beq_npc", 32'(NPCOp), 32'd1);
            tick();
            settle_state("beq_back", ST_FETCH);
        end
        Zero = 1'b0;

        // jalr, then jal
        set_ir(7'b1100111, 7'd0, 3'b000);
        fetch("jalr");
        tick();
        settle_state("jalr_jump", ST_JUMP);
        check("jalr_rw", 32'(RegWrite), 32'd1);
        check("jalr_wdsel", 32'(WDSel), 32'd2);
        check("jalr_npc", 32'(NPCOp), 32'd4);
        check("jalr_ext", 32'(EXTOp), 32'h10);
        check("jalr_pcw", 32'(PCWrite), 32'd1);
        tick();
        settle_state("jalr_back", ST_FETCH);
        set_ir(7'b1101111, 7'd0, 3'b101);
        fetch("jal");
        tick();
        settle_state("jal_jump", ST_JUMP);
        check("jal_npc", 32'(NPCOp), 32'd2);
        check("jal_ext", 32'(EXTOp), 32'h01);
        tick();
        settle_state("jal_back", ST_FETCH);

        // slli uses shamt immediate
        set_ir(7'b0010011, 7'd0, 3'b001);
        fetch("slli");
        tick();
        settle_state("slli_exec", ST_EXEC);
        check("slli_aluop", 32'(ALUOp), 32'h0F);
        check("slli_ext", 32'(EXTOp), 32'h20);
        check("slli_alusrc", 32'(ALUSrc), 32'd1);
        tick();
        settle_state("slli_wb", ST_WB);
        tick();
        settle_state("slli_back", ST_FETCH);

        // illegal opcode: trap is sticky regardless of inputs
        set_ir(7'b1111111, 7'd0, 3'd0);
        fetch("ill");
        tick();
        settle_state("ill_trap", ST_TRAP);
        check("ill_trap_flag", 32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            Zero = 1'($urandom_range(0, 1));
            settle_state("ill_hold", ST_TRAP);
            check("ill_strobes", 32'(strobes), 32'd0);
            tick();
        end
        mem_ready = 1'b0;
        Zero = 1'b0;
        do_reset("ill");

        // FETCH timeout on the 4th stalled cycle
        set_ir(7'b0110011, 7'd0, 3'd0);
        for (int i = 2; i <= TO; i++) begin
            tick();
            settle_state("to_stall", ST_FETCH);
        end
        tick();
        settle_state("to_trap", ST_TRAP);
        check("to_cause", 32'(trap_cause), 32'd2);
        check("to_flag", 32'(trap), 32'd1);
        do_reset("to");

        // ready on the last allowed cycle wins
        for (int i = 2; i <= TO; i++) begin
            tick();
            settle_state("to_edge_stall", ST_FETCH);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        settle_state("to_edge_decode", ST_DECODE);
        check("to_edge_notrap", 32'(trap), 32'd0);
        tick();
        tick();
        tick();
        settle_state("to_edge_back", ST_FETCH);

        // MEM-phase timeout on a load
        set_ir(7'b0000011, 7'd0, 3'b010);
        fetch("memto");
        tick();
        tick();
        settle_state("memto_mem", ST_MEM);
        for (int i = 2; i <= TO; i++) begin
            tick();
            settle_state("memto_stall", ST_MEM);
        end
        tick();
        settle_state("memto_trap", ST_TRAP);
        check("memto_cause", 32'(trap_cause), 32'd2);
        do_reset("memto");

        // jalr with nonzero funct3 is illegal
        set_ir(7'b1100111, 7'd0, 3'b001);
        fetch("badjalr");
        tick();
        settle_state("badjalr_trap", ST_TRAP);
        check("badjalr_cause", 32'(trap_cause), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
